spmv_result_collector: RTL and testbench
========================================

Name: spmv_result_collector

Overview:
- Sits directly downstream of the CSR sparse-matrix × dense-vector multiply-accumulate stage.
- Detects each completed row result (the `valid` level rising) and each empty row (`zeros` pulse), and tags each with a row index.
- Buffers the results in a FIFO and streams them out over a ready/valid interface.
- Asserts `done` once all NUM_ROWS rows have been accepted and drained.

Parameters:
- DATA_W, 64, width of each lane (dataout1/dataout2)
- NUM_ROWS, 560, rows per matrix pass
- ROW_W, 10, row-index width; must satisfy 2^ROW_W ≥ NUM_ROWS
- FIFO_DEPTH, 16, FIFO entries; power of two, ≥ 4

Ports:
- clk, input, 1, system clock; all state updates on posedge
- rst, input, 1, asynchronous active-low reset
- clear, input, 1, synchronous restart of a pass; active-high, single cycle
- valid, input, 1, upstream row-result-ready level; may stay high for many cycles
- zeros, input, 1, upstream empty-row pulse
- dataout1, input, DATA_W, lane-0 accumulated result
- dataout2, input, DATA_W, lane-1 accumulated result
- out_valid, output, 1, FIFO head valid
- out_ready, input, 1, consumer accepts head
- out_data, output, 2*DATA_W, {lane1, lane0} of head entry
- out_row, output, ROW_W, row index of head entry
- level, output, log2(FIFO_DEPTH)+1, current FIFO occupancy
- done, output, 1, pass complete
- overflow, output, 1, sticky: an event was lost

Behaviour:
- Reset (rst=0, async): FIFO pointers and level=0, row_cnt=0, valid_d=0, pend=0, state=COLLECT. Outputs out_valid=0, out_data=0, out_row=0, done=0, overflow=0.
- clear=1: same effect as reset, but synchronous. clear takes priority over any event in that cycle.
- Event detection:
  - vrise = valid & ~valid_d, where valid_d is the registered valid.
  - A vrise event captures {dataout2, dataout1} in the same cycle.
  - A zeros event captures {0, 0}. zeros held high for k cycles counts as k empty rows.
- Row tagging: each event takes row_cnt as its row index, then row_cnt increments. Events arriving once row_cnt == NUM_ROWS are discarded and set overflow.
- Simultaneous vrise and zeros:
  - The zero row is enqueued first with index row_cnt.
  - The captured valid row is held in the single pending register `pend` with index row_cnt+1; row_cnt advances by 2.
  - pend is enqueued on the next cycle, ahead of any new event.
  - If a new event arrives while pend is occupied, pend is enqueued and the new event goes into pend.
  - If pend is occupied and the FIFO is full, any further event is dropped and sets overflow.
- Enqueue: at most one FIFO write per cycle.
  - A write when full is dropped and sets overflow. row_cnt still advances, so the lost index is visible as a gap in out_row.
- Dequeue: when out_valid & out_ready, the head is popped.
  - out_data and out_row are registered FWFT: the head is valid one cycle after it is written into an empty FIFO.
  - Pop and push in the same cycle: level is unchanged. A push into a full FIFO is allowed in a cycle that also pops.
- Latency: event at cycle t → out_valid at t+1 if the FIFO was empty and pend was free; t+2 if the event went through pend.
- State machine:
  - COLLECT → DRAIN when row_cnt reaches NUM_ROWS and pend is empty.
  - DRAIN → DONE when level == 0.
  - In DONE, done=1 is held until clear or rst. Further events in DONE are ignored and set overflow.
- Widths: row_cnt is ROW_W+1 bits internally; out_row is the low ROW_W bits. level counts 0..FIFO_DEPTH with no wrap.
- overflow is sticky; only rst or clear clears it.

Test Plan:
- Basic flow: out_ready=1; valid rises three times with dataout1=5/7/9 and dataout2=1/2/3 → out_row 0,1,2 with out_data {1,5}, {2,7}, {3,9}, each appearing one cycle after its rise; valid held high 20 cycles yields exactly one entry.
- Empty rows: zeros pulses twice, then a valid rise → entries row0 = 0, row1 = 0, row2 = data; overflow stays 0.
- Simultaneous events: vrise and zeros in the same cycle with dataout1=0xAA → row n = 0 first, row n+1 = 0xAA on the next pop; row_cnt advances by 2.
- Backpressure: out_ready=0; 18 events into a FIFO_DEPTH=16 FIFO → level saturates at 16, pend holds one, the 18th event sets overflow; releasing out_ready drains rows 0..16 in order.
- Completion: 560 mixed events with out_ready toggling → done rises on the cycle level returns to 0 after the 560th pop; a 561st event sets overflow and done stays 1.
- Reset mid-operation: assert rst (async, mid-cycle) with level=5 → out_valid, level and done drop to 0 immediately; after release, the next event gets row index 0.

Source files
------------

// File: rtl/spmv_result_collector.sv
// Result collector behind the CSR SpMV multiply-accumulate stage: tags completed
// and empty rows with a row index, buffers them and streams them over ready/valid.
module spmv_result_collector #(
  parameter int DATA_W     = 64,
  parameter int NUM_ROWS   = 560,
  parameter int ROW_W      = 10,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        valid,
  input  logic                        zeros,
  input  logic [DATA_W-1:0]           dataout1,
  input  logic [DATA_W-1:0]           dataout2,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [2*DATA_W-1:0]         out_data,
  output logic [ROW_W-1:0]            out_row,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        done,
  output logic                        overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = ROW_W + 1;

  typedef struct packed {
    logic [ROW_W-1:0]    row;
    logic [2*DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {S_COLLECT, S_DRAIN, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] row_cnt_q, row_cnt_d;
  logic          valid_q;
  logic          pend_vld_q, pend_vld_d;
  entry_t        pend_q, pend_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  entry_t        mem [FIFO_DEPTH];

  logic          vrise, accept, full, pop, can_write, wr_en, dropped;
  logic          z_ok, v_ok;
  logic [CW-1:0] v_idx;
  entry_t        z_entry, v_entry, first, second, head;
  logic          first_vld, second_vld, third_vld;

  assign vrise     = valid & ~valid_q;
  assign accept    = (state_q != S_DONE);
  assign full      = (level_q == LW'(FIFO_DEPTH));
  assign out_valid = (level_q != '0);
  assign pop       = out_valid & out_ready;
  assign can_write = ~full | pop;

  assign head     = mem[rd_ptr_q];
  assign out_data = out_valid ? head.data : '0;
  assign out_row  = out_valid ? head.row  : '0;
  assign level    = level_q;
  assign done     = (state_q == S_DONE);
  assign overflow = overflow_q;

  // NOTE: every variable driven here gets a value before any branch, so no latch can be inferred.
  always_comb begin
    z_ok    = accept & zeros & (row_cnt_q < CW'(NUM_ROWS));
    v_idx   = row_cnt_q + CW'(z_ok);
    v_ok    = accept & vrise & (v_idx < CW'(NUM_ROWS));
    z_entry = '{row: row_cnt_q[ROW_W-1:0], data: '0};
    v_entry = '{row: v_idx[ROW_W-1:0], data: {dataout2, dataout1}};

    // Candidates in order of age: held pend entry, then the empty row, then the valid row.
    first      = pend_vld_q ? pend_q : (z_ok ? z_entry : v_entry);
    first_vld  = pend_vld_q | z_ok | v_ok;
    second     = (pend_vld_q & z_ok) ? z_entry : v_entry;
    second_vld = pend_vld_q ? (z_ok | v_ok) : (z_ok & v_ok);
    third_vld  = pend_vld_q & z_ok & v_ok;

    wr_en      = first_vld & can_write;
    pend_vld_d = first_vld;
    pend_d     = first;
    dropped    = second_vld;
    if (can_write) begin
      pend_vld_d = second_vld;
      pend_d     = second;
      dropped    = third_vld;
    end

    overflow_d = overflow_q | dropped | (zeros & ~z_ok) | (vrise & ~v_ok);
    row_cnt_d  = row_cnt_q + CW'(z_ok) + CW'(v_ok);
    level_d    = level_q + LW'(wr_en) - LW'(pop);

    state_d = state_q;
    case (state_q)
      S_COLLECT: if (row_cnt_d == CW'(NUM_ROWS) && !pend_vld_d)
                   state_d = (level_d == '0) ? S_DONE : S_DRAIN;
      S_DRAIN:   if (level_d == '0) state_d = S_DONE;
      default:   ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_COLLECT;
      row_cnt_q  <= '0;
      valid_q    <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      state_q    <= S_COLLECT;
      row_cnt_q  <= '0;
      valid_q    <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      valid_q    <= valid;
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
      wr_ptr_q   <= wr_ptr_q + AW'(wr_en);
      rd_ptr_q   <= rd_ptr_q + AW'(pop);
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the storage array has no reset; level gates every read so stale contents never escape.
  always_ff @(posedge clk) begin
    if (wr_en && !clear) mem[wr_ptr_q] <= first;
  end

endmodule

// File: tb/tb_spmv_result_collector.sv
// Self-checking bench for spmv_result_collector: directed table, hand sequences
// and randomized traffic against a queue-based reference model.
module tb_spmv_result_collector;
  localparam int DATA_W   = 64;
  localparam int NUM_ROWS = 560;
  localparam int ROW_W    = 10;
  localparam int DEPTH    = 16;

  logic clk = 1'b0;
  logic rst, clear, valid, zeros, out_ready;
  logic [DATA_W-1:0]   d1, d2;
  logic                out_valid, done, overflow;
  logic [2*DATA_W-1:0] out_data;
  logic [ROW_W-1:0]    out_row;
  logic [4:0]          level;

  spmv_result_collector #(
    .DATA_W(DATA_W), .NUM_ROWS(NUM_ROWS), .ROW_W(ROW_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .valid(valid), .zeros(zeros),
    .dataout1(d1), .dataout2(d2), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .level(level), .done(done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] pk(input logic [63:0] lane0, input logic [63:0] lane1);
    return {lane1, lane0};
  endfunction

  // Reference model: ordered list of tagged rows, a one-slot overflow holder, counters.
  typedef struct { int row; logic [127:0] data; } ent_t;
  ent_t mq[$];
  ent_t mpend[$];
  int   m_rows;
  bit   m_vd, m_ovf, m_done;

  task automatic model_reset();
    mq.delete();
    mpend.delete();
    m_rows = 0;
    m_vd   = 1'b0;
    m_ovf  = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic tag_event(input logic [127:0] data, inout ent_t items[$]);
    ent_t e;
    if (!m_done && m_rows < NUM_ROWS) begin
      e.row  = m_rows;
      e.data = data;
      items.push_back(e);
      m_rows++;
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic model_step(input bit cl, input bit v, input bit z,
                            input logic [63:0] a, input logic [63:0] b, input bit r);
    ent_t items[$];
    bit   popped;
    if (cl) begin
      model_reset();
      return;
    end
    popped = (mq.size() > 0) && r;
    items  = mpend;
    mpend.delete();
    if (z)         tag_event('0, items);
    if (v && !m_vd) tag_event(pk(a, b), items);
    if (popped) void'(mq.pop_front());
    if (items.size() > 0 && mq.size() < DEPTH) mq.push_back(items.pop_front());
    if (items.size() > 0) mpend.push_back(items.pop_front());
    if (items.size() > 0) m_ovf = 1'b1;
    m_vd = v;
    if (!m_done && m_rows == NUM_ROWS && mpend.size() == 0 && mq.size() == 0) m_done = 1'b1;
  endtask

  task automatic compare_model();
    check("m_out_valid", 128'(out_valid), 128'(mq.size() > 0));
    check("m_level", 128'(level), 128'(mq.size()));
    if (mq.size() > 0) begin
      check("m_out_row", 128'(out_row), 128'(mq[0].row));
      check("m_out_data", out_data, mq[0].data);
    end else begin
      check("m_out_data_idle", out_data, '0);
    end
    check("m_done", 128'(done), 128'(m_done));
    check("m_overflow", 128'(overflow), 128'(m_ovf));
  endtask

  // Drive one cycle from the falling edge, advance the model, compare at the next falling edge.
  task automatic step(input bit cl, input bit v, input bit z,
                      input logic [63:0] a, input logic [63:0] b, input bit r);
    clear = cl; valid = v; zeros = z; d1 = a; d2 = b; out_ready = r;
    model_step(cl, v, z, a, b, r);
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  typedef struct {
    bit           v;
    bit           z;
    logic [63:0]  a;
    logic [63:0]  b;
    bit           ov;
    logic [9:0]   orow;
    logic [127:0] odata;
    int           lvl;
  } vec_t;
  vec_t tbl[14];

  task automatic setv(input int i, input bit v, input bit z, input logic [63:0] a,
                      input logic [63:0] b, input bit ov, input logic [9:0] orow,
                      input logic [127:0] odata, input int lvl);
    tbl[i].v = v; tbl[i].z = z; tbl[i].a = a; tbl[i].b = b;
    tbl[i].ov = ov; tbl[i].orow = orow; tbl[i].odata = odata; tbl[i].lvl = lvl;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    int cyc;
    // out_ready held at 1; expected values are the outputs after the sampling edge.
    setv(0,  1'b1, 1'b0, 64'd5,    64'd1,    1'b1, 10'd0, pk(64'd5, 64'd1),     1);
    setv(1,  1'b0, 1'b0, 64'd0,    64'd0,    1'b0, 10'd0, '0,                   0);
    setv(2,  1'b1, 1'b0, 64'd7,    64'd2,    1'b1, 10'd1, pk(64'd7, 64'd2),     1);
    setv(3,  1'b0, 1'b0, 64'd0,    64'd0,    1'b0, 10'd0, '0,                   0);
    setv(4,  1'b1, 1'b0, 64'd9,    64'd3,    1'b1, 10'd2, pk(64'd9, 64'd3),     1);
    setv(5,  1'b1, 1'b0, 64'd9,    64'd3,    1'b0, 10'd0, '0,                   0);
    setv(6,  1'b1, 1'b0, 64'd9,    64'd3,    1'b0, 10'd0, '0,                   0);
    setv(7,  1'b0, 1'b1, 64'd0,    64'd0,    1'b1, 10'd3, '0,                   1);
    setv(8,  1'b0, 1'b1, 64'd0,    64'd0,    1'b1, 10'd4, '0,                   1);
    setv(9,  1'b1, 1'b0, 64'h11,   64'h22,   1'b1, 10'd5, pk(64'h11, 64'h22),   1);
    setv(10, 1'b0, 1'b0, 64'd0,    64'd0,    1'b0, 10'd0, '0,                   0);
    setv(11, 1'b1, 1'b1, 64'hAA,   64'd0,    1'b1, 10'd6, '0,                   1);
    setv(12, 1'b1, 1'b0, 64'hAA,   64'd0,    1'b1, 10'd7, pk(64'hAA, 64'd0),    1);
    setv(13, 1'b0, 1'b0, 64'd0,    64'd0,    1'b0, 10'd0, '0,                   0);

    rst = 1'b0; clear = 1'b0; valid = 1'b0; zeros = 1'b0;
    d1 = '0; d2 = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_out_valid", 128'(out_valid), '0);
    check("rst_level", 128'(level), '0);
    check("rst_out_data", out_data, '0);
    check("rst_out_row", 128'(out_row), '0);
    check("rst_done", 128'(done), '0);
    check("rst_overflow", 128'(overflow), '0);
    rst = 1'b1;
    @(negedge clk);

    // Directed table: basic flow, empty rows, simultaneous events.
    for (int i = 0; i < 14; i++) begin
      step(1'b0, tbl[i].v, tbl[i].z, tbl[i].a, tbl[i].b, 1'b1);
      check($sformatf("tbl%0d_valid", i), 128'(out_valid), 128'(tbl[i].ov));
      check($sformatf("tbl%0d_row", i), 128'(out_row), 128'(tbl[i].orow));
      check($sformatf("tbl%0d_data", i), out_data, tbl[i].odata);
      check($sformatf("tbl%0d_level", i), 128'(level), 128'(tbl[i].lvl));
    end
    check("tbl_overflow", 128'(overflow), '0);

    // valid held high for 20 cycles yields one entry.
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 64'h33, 64'h44, 1'b0);
    check("hold_level", 128'(level), 128'd1);
    check("hold_row", 128'(out_row), '0);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);

    // Backpressure: 18 events into a full FIFO with out_ready low.
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 18; i++) begin
      step(1'b0, 1'b1, 1'b0, 64'(100 + i), 64'(i), 1'b0);
      if (i == 16) begin
        check("bp_level_full", 128'(level), 128'd16);
        check("bp_no_ovf_yet", 128'(overflow), '0);
      end
      step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    end
    check("bp_level", 128'(level), 128'd16);
    check("bp_overflow", 128'(overflow), 128'd1);
    k = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) begin
        check("bp_row_order", 128'(out_row), 128'(k));
        k++;
      end
      step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    end
    check("bp_drained", 128'(k), 128'd17);

    // Randomized stress with frequent backpressure.
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 400; i++)
      step(1'b0, ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0),
           {$urandom(), $urandom()}, {$urandom(), $urandom()}, ($urandom_range(0, 1) == 1));

    // Full pass of NUM_ROWS mixed events with toggling out_ready.
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    cyc = 0;
    while (!m_done && cyc < 20000) begin
      step(1'b0, ($urandom_range(0, 1) == 1), ($urandom_range(0, 4) == 0),
           {$urandom(), $urandom()}, {$urandom(), $urandom()}, (cyc % 3) != 0);
      cyc++;
    end
    check("pass_done", 128'(done), 128'd1);
    step(1'b0, 1'b0, 1'b1, '0, '0, 1'b1);
    check("extra_ovf", 128'(overflow), 128'd1);
    check("extra_done", 128'(done), 128'd1);

    // Asynchronous reset mid-cycle while done is high.
    #2 rst = 1'b0;
    #1;
    check("arst_done", 128'(done), '0);
    check("arst_ovf", 128'(overflow), '0);
    model_reset();
    clear = 1'b0; valid = 1'b0; zeros = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Asynchronous reset mid-cycle with five entries buffered.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 64'(i), '0, 1'b0);
      step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    end
    check("arst_pre_level", 128'(level), 128'd5);
    #2 rst = 1'b0;
    #1;
    check("arst_out_valid", 128'(out_valid), '0);
    check("arst_level", 128'(level), '0);
    check("arst_done2", 128'(done), '0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b1, 1'b0, 64'h55, 64'h66, 1'b1);
    check("post_rst_valid", 128'(out_valid), 128'd1);
    check("post_rst_row", 128'(out_row), '0);
    check("post_rst_data", out_data, pk(64'h55, 64'h66));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
